// File: rtl/io_input_port.sv
// Buffers source bytes in a small FIFO and presents them to the processor over an active-low four-phase hs/ack handshake.
// Latency: push edge to strobe low is 2 edges; ack edges reach the FSM directly, or 2 edges later with IO_IN_ACK_SYNC_EN.
// Backpressure: src_ready drops while the FIFO is full; there is no full-bypass, so a same-cycle pop does not admit a push.
module io_input_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     g_clk,
    input  logic                     g_clr,
    input  logic                     src_valid,
    input  logic [WIDTH-1:0]         src_data,
    output logic                     src_ready,
    output logic [WIDTH-1:0]         input_bus,
    output logic                     in_dev_hs,
    input  logic                     in_dev_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               xfer_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PRESENT,
        S_RELEASE
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    state_t           r_state;
    logic [WIDTH-1:0] r_input_bus;
    logic             r_in_dev_hs;
    logic [7:0]       r_xfer_cnt;
    logic             w_push;
    logic             w_pop;
    logic             w_ack_s;

`ifdef IO_IN_ACK_SYNC_EN
    logic r_ack_meta;
    logic r_ack_sync;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_ack_meta <= 1'b1;
            r_ack_sync <= 1'b1;
        end else begin
            r_ack_meta <= in_dev_ack;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack_s = r_ack_sync;
`else
    assign w_ack_s = in_dev_ack;
`endif

    assign src_ready  = (r_count < (AW+1)'(DEPTH));
    assign w_push     = src_valid & src_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0) && w_ack_s;
    assign fifo_count = r_count;
    assign input_bus  = r_input_bus;
    assign in_dev_hs  = r_in_dev_hs;
    assign xfer_cnt   = r_xfer_cnt;

    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= src_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_state     <= S_IDLE;
            r_input_bus <= '0;
            r_in_dev_hs <= 1'b1;
            r_xfer_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_dev_hs <= 1'b1;
                    if (w_pop) begin
                        r_input_bus <= r_mem[r_rd_ptr];
                        r_state     <= S_SETUP;
                    end
                end
                // One full cycle of stable data before the strobe falls.
                S_SETUP: begin
                    r_in_dev_hs <= 1'b0;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (!w_ack_s) begin
                        r_in_dev_hs <= 1'b1;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_ack_s) begin
                        r_xfer_cnt <= r_xfer_cnt + 8'd1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_in_dev_hs <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
